vga_framebuf: RTL
=================

VGA_FRAMEBUF -- requirements
Module: vga_framebuf

Interface
REQ-001 SHALL have parameter H_AW, default 10, pixel-column address width.
REQ-002 SHALL have parameter V_AW, default 9, pixel-row address width.
REQ-003 SHALL have parameter PIX_W, default 24, pixel width, packed {R,G,B}.
REQ-004 SHALL have parameter SCALE_LOG2, default 0, display pixel replication factor 2^SCALE_LOG2 per axis.
REQ-005 SHALL have parameters H_ACTIVE, default 640, and V_ACTIVE, default 480, visible resolution in display pixels.
REQ-006 SHALL have parameter BG_COLOR, default 24'h000000, colour for blanked or out-of-range reads.
REQ-007 SHALL have ports, clock and reset first: clk input 1 system/pixel clock; rst input 1 asynchronous active-high reset.
REQ-008 SHALL have display ports: h_addr input H_AW; v_addr input V_AW; valid input 1, active-video flag; vsync input 1, active-low sync; vga_data output PIX_W.
REQ-009 SHALL have write ports: wr_en input 1; wr_x input H_AW; wr_y input V_AW; wr_data input PIX_W; wr_ready output 1; wr_err output 1.
REQ-010 SHALL have swap ports: swap_req input 1; swap_done output 1; front_sel output 1.

Function
REQ-011 SHALL hold two banks, each (H_ACTIVE>>SCALE_LOG2)*(V_ACTIVE>>SCALE_LOG2) words of PIX_W, addressed y*(H_ACTIVE>>SCALE_LOG2)+x.
REQ-012 SHALL read from the front bank (index front_sel) and write only to the back bank (~front_sel); same-bank conflicts cannot occur.
REQ-013 SHALL, for read, use h_addr>>SCALE_LOG2 and v_addr>>SCALE_LOG2; sample inputs in cycle N; drive vga_data in cycle N+1 (latency 1, registered).
REQ-014 SHALL output BG_COLOR when sampled valid=0, h_addr>=H_ACTIVE, or v_addr>=V_ACTIVE.
REQ-015 SHALL accept a write when wr_en & wr_ready; write is in scaled coordinates; data visible after next swap.
REQ-016 SHALL drop a write with wr_x>=(H_ACTIVE>>SCALE_LOG2) or wr_y>=(V_ACTIVE>>SCALE_LOG2) and pulse wr_err for one cycle (next cycle); memory is unchanged.
REQ-017 SHALL detect a vsync falling edge: vsync_q registered copy, reset 1; fall = vsync_q & ~vsync.
REQ-018 SHALL implement FSM IDLE/PENDING: IDLE --swap_req--> PENDING; PENDING --fall--> IDLE with front_sel toggled and swap_done pulsed for one cycle, both in the cycle after the fall.
REQ-019 SHALL drive wr_ready=1 in IDLE, 0 in PENDING; writes attempted in PENDING are not performed and not flagged as errors.
REQ-020 SHALL ignore swap_req while PENDING; swap_req coincident with a fall while IDLE goes to PENDING and swaps at the following fall, not the current one.
REQ-021 SHALL apply the read bank change only to reads sampled after front_sel toggles; no mid-frame swap is possible.

Reset
REQ-022 SHALL on rst: state IDLE, front_sel=0, vsync_q=1, vga_data=BG_COLOR, swap_done=0, wr_err=0, wr_ready=1; memory contents are not cleared.
REQ-023 SHALL abandon a PENDING swap on rst mid-operation; no swap_done is produced for it.

Structure
REQ-024 SHALL take H_ACTIVE, V_ACTIVE, BG_COLOR defaults and the FSM state encoding from the shared vga_pkg package.
REQ-025 SHALL instantiate sub-module fb_bank (1 sync write port, 1 registered read port, parameterised depth/width) twice.

Verification
REQ-026 SHALL check: reset, then valid=1, h=0, v=0 -> vga_data=BG_COLOR; front_sel=0; wr_ready=1.
REQ-027 SHALL check: write (3,2)=24'hFF0000, swap_req, vsync 1->0 -> swap_done pulse, front_sel=1; read h=3, v=2 -> 24'hFF0000 one cycle later.
REQ-028 SHALL check: with SCALE_LOG2=1, write (5,7)=24'h00FF00 then swap -> reads at (10..11, 14..15) all 24'h00FF00.
REQ-029 SHALL check: write x=H_ACTIVE -> wr_err one-cycle pulse; h=700, valid=1 -> BG_COLOR.
REQ-030 SHALL check: swap_req then write in PENDING -> wr_ready=0, memory unchanged; swap_req on the same cycle as a fall -> swap only at the second fall.
REQ-031 SHALL check: rst asserted while PENDING -> front_sel=0, IDLE, no swap_done at later falls.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared defaults and swap-controller state encoding for the double-buffered VGA framebuffer.
package vga_pkg;

  localparam int          H_ACTIVE_DEF = 640;
  localparam int          V_ACTIVE_DEF = 480;
  localparam logic [23:0] BG_COLOR_DEF = 24'h000000;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } swap_state_e;

endpackage

// File: rtl/fb_bank.sv
// One framebuffer bank: synchronous write port and a registered read port.
module fb_bank #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_d;
  logic [DW-1:0] rd_data_q;

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // No reset here: pixel storage is deliberately left untouched by rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_framebuf.sv
// Double-buffered VGA framebuffer: display reads the front bank, writers fill the back bank,
// and a requested swap takes effect at the next vsync falling edge.
module vga_framebuf
  import vga_pkg::*;
#(
  parameter int               H_AW       = 10,
  parameter int               V_AW       = 9,
  parameter int               PIX_W      = 24,
  parameter int               SCALE_LOG2 = 0,
  parameter int               H_ACTIVE   = H_ACTIVE_DEF,
  parameter int               V_ACTIVE   = V_ACTIVE_DEF,
  parameter logic [PIX_W-1:0] BG_COLOR   = PIX_W'(BG_COLOR_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [H_AW-1:0]  h_addr,
  input  logic [V_AW-1:0]  v_addr,
  input  logic             valid,
  input  logic             vsync,
  output logic [PIX_W-1:0] vga_data,
  input  logic             wr_en,
  input  logic [H_AW-1:0]  wr_x,
  input  logic [V_AW-1:0]  wr_y,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_ready,
  output logic             wr_err,
  input  logic             swap_req,
  output logic             swap_done,
  output logic             front_sel
);

  localparam int H_CELLS = H_ACTIVE >> SCALE_LOG2;
  localparam int V_CELLS = V_ACTIVE >> SCALE_LOG2;
  localparam int DEPTH   = H_CELLS * V_CELLS;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  swap_state_e state_q, state_d;
  logic        front_sel_q, front_sel_d;
  logic        swap_done_q, swap_done_d;
  logic        wr_err_q, wr_err_d;
  logic        vsync_q;
  logic        rd_bg_q, rd_bg_d;
  logic        rd_sel_q;
  logic        fall;

  logic [H_AW-1:0]  rd_x;
  logic [V_AW-1:0]  rd_y;
  logic [AW-1:0]    rd_addr;
  logic [AW-1:0]    wr_addr;
  logic             wr_oob;
  logic             wr_accept;
  logic             wr_ok;
  logic [PIX_W-1:0] rd_data0;
  logic [PIX_W-1:0] rd_data1;

  assign fall = vsync_q & ~vsync;

  always_comb begin
    rd_x    = h_addr >> SCALE_LOG2;
    rd_y    = v_addr >> SCALE_LOG2;
    rd_addr = AW'(rd_y) * AW'(H_CELLS) + AW'(rd_x);
    rd_bg_d = ~valid | (32'(h_addr) >= H_ACTIVE) | (32'(v_addr) >= V_ACTIVE);
  end

  always_comb begin
    wr_addr   = AW'(wr_y) * AW'(H_CELLS) + AW'(wr_x);
    wr_oob    = (32'(wr_x) >= H_CELLS) | (32'(wr_y) >= V_CELLS);
    wr_accept = wr_en & wr_ready;
    wr_ok     = wr_accept & ~wr_oob;
    wr_err_d  = wr_accept & wr_oob;
  end

  // A swap request arriving with a fall only arms the swap; the toggle waits for the next fall.
  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    swap_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (swap_req) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (fall) begin
          state_d     = ST_IDLE;
          front_sel_d = ~front_sel_q;
          swap_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      front_sel_q <= 1'b0;
      swap_done_q <= 1'b0;
      wr_err_q    <= 1'b0;
      vsync_q     <= 1'b1;
      rd_bg_q     <= 1'b1;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      swap_done_q <= swap_done_d;
      wr_err_q    <= wr_err_d;
      vsync_q     <= vsync;
      rd_bg_q     <= rd_bg_d;
      rd_sel_q    <= front_sel_q;
    end
  end

  fb_bank #(.DEPTH(DEPTH), .AW(AW), .DW(PIX_W)) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_ok & front_sel_q),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data0)
  );

  fb_bank #(.DEPTH(DEPTH), .AW(AW), .DW(PIX_W)) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_ok & ~front_sel_q),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data1)
  );

  // rd_sel_q remembers which bank was front when the read was sampled.
  always_comb begin
    vga_data = rd_bg_q ? BG_COLOR : (rd_sel_q ? rd_data1 : rd_data0);
  end

  assign wr_ready  = (state_q == ST_IDLE);
  assign wr_err    = wr_err_q;
  assign swap_done = swap_done_q;
  assign front_sel = front_sel_q;

endmodule
